memory_io_bridge: RTL and testbench

- Sits directly downstream of the CPU memory port; sole consumer of its address, write-enable and write-data.
- Returns read data to the CPU with a fixed 1-cycle latency.
- Decodes the address space:
  - low addresses go to synchronous block RAM;
  - the top page goes to memory-mapped I/O: switches, LEDs, a free-running timer, and an output FIFO with a valid/ready consumer port.

---
 rtl/memory_io_pkg.sv | 23 ++
 rtl/output_fifo.sv | 55 +++++
 rtl/memory_io_bridge.sv | 177 +++++++++++++++++
 tb/tb_memory_io_bridge.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/memory_io_pkg.sv
// Shared constants for the CPU memory/I/O bridge: register offsets, STATUS
// bit positions and the data-path width.
package memory_io_pkg;

    localparam int DATA_WIDTH = 16;

    typedef logic [DATA_WIDTH-1:0] word_t;

    localparam word_t REG_SWITCH    = 16'h0000;
    localparam word_t REG_LED       = 16'h0001;
    localparam word_t REG_TIMER     = 16'h0002;
    localparam word_t REG_FIFO_DATA = 16'h0003;
    localparam word_t REG_STATUS    = 16'h0004;
    localparam word_t REG_COMPARE   = 16'h0005;

    localparam int STATUS_FULL_BIT     = 0;
    localparam int STATUS_EMPTY_BIT    = 1;
    localparam int STATUS_OVERFLOW_BIT = 2;
    localparam int STATUS_IRQ_BIT      = 3;
    localparam int STATUS_COUNT_LSB    = 4;
    localparam int STATUS_COUNT_MSB    = 8;

endpackage

// File: rtl/output_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO is still
// accepted when a pop happens in the same cycle.
module output_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count,
    output logic             o_accept
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;

    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == CW'(DEPTH));
    assign w_pop    = i_pop & ~o_empty;
    assign o_accept = i_push & (~o_full | w_pop);
    assign o_count  = r_count;
    // Head is forced to zero while empty so stale storage never leaks out.
    assign o_data   = o_empty ? '0 : r_mem[r_rptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (o_accept) r_wptr <= r_wptr + AW'(1);
            if (w_pop)    r_rptr <= r_rptr + AW'(1);
            case ({o_accept, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (o_accept) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/memory_io_bridge.sv
// CPU memory-port bridge: block RAM below IO_BASE, memory-mapped switches,
// LEDs, timer and output FIFO above. Optional macro: MEMIO_TIMER_COMPARE_EN.
module memory_io_bridge
    import memory_io_pkg::*;
#(
    parameter logic [15:0] IO_BASE      = 16'hFF00,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          TIMER_DIVIDE = 50000,
    parameter int          SWITCH_WIDTH = 10
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [15:0]             cpu_address,
    input  logic                    cpu_write_enable,
    input  logic [15:0]             cpu_write_data,
    output logic [15:0]             cpu_read_data,
    output logic [15:0]             ram_address,
    output logic                    ram_write_enable,
    output logic [15:0]             ram_write_data,
    input  logic [15:0]             ram_read_data,
    input  logic [SWITCH_WIDTH-1:0] switches,
    output logic [SWITCH_WIDTH-1:0] leds,
    output logic                    out_valid,
    output logic [15:0]             out_data,
    input  logic                    out_ready,
    output logic                    timer_irq
);

    localparam int PW = (TIMER_DIVIDE > 2) ? $clog2(TIMER_DIVIDE) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                    w_is_io;
    logic [15:0]             w_offset;
    logic                    w_wr_io;
    logic                    w_wr_led;
    logic                    w_wr_timer;
    logic                    w_push;
    logic                    w_wr_status;
    logic                    w_tick;
    logic [15:0]             w_timer_inc;
    logic [15:0]             w_io_rdata;
    logic [15:0]             w_status;
    logic                    w_full;
    logic                    w_empty;
    logic [CW-1:0]           w_count;
    logic                    w_accept;
    logic                    w_irq;

    logic [SWITCH_WIDTH-1:0] r_sw_meta;
    logic [SWITCH_WIDTH-1:0] r_sw_sync;
    logic [SWITCH_WIDTH-1:0] r_leds;
    logic [15:0]             r_timer;
    logic [PW-1:0]           r_prescaler;
    logic                    r_overflow;
    logic                    r_is_io;
    logic [15:0]             r_io_data;

    assign w_is_io     = (cpu_address >= IO_BASE);
    assign w_offset    = cpu_address - IO_BASE;
    assign w_wr_io     = cpu_write_enable & w_is_io;
    assign w_wr_led    = w_wr_io & (w_offset == REG_LED);
    assign w_wr_timer  = w_wr_io & (w_offset == REG_TIMER);
    assign w_push      = w_wr_io & (w_offset == REG_FIFO_DATA);
    assign w_wr_status = w_wr_io & (w_offset == REG_STATUS);
    assign w_tick      = (r_prescaler == PW'(TIMER_DIVIDE - 1));
    assign w_timer_inc = r_timer + 16'd1;

    assign ram_address      = cpu_address;
    assign ram_write_data   = cpu_write_data;
    assign ram_write_enable = cpu_write_enable & ~w_is_io;
    assign cpu_read_data    = r_is_io ? r_io_data : ram_read_data;
    assign leds             = r_leds;

    output_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_output_fifo (
        .clock    (clock),
        .reset    (reset),
        .i_push   (w_push),
        .i_pop    (out_ready),
        .i_data   (cpu_write_data),
        .o_data   (out_data),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_count  (w_count),
        .o_accept (w_accept)
    );

    assign out_valid = ~w_empty;

`ifdef MEMIO_TIMER_COMPARE_EN
    logic        w_wr_compare;
    logic        w_irq_set;
    logic [15:0] r_compare;
    logic        r_irq;

    assign w_wr_compare = w_wr_io & (w_offset == REG_COMPARE);
    assign w_irq_set    = w_tick & ~w_wr_timer & (w_timer_inc == r_compare);
    assign w_irq        = r_irq;
    assign timer_irq    = r_irq;

    // A match in the same cycle as a COMPARE write keeps the flag set.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_compare <= 16'hFFFF;
            r_irq     <= 1'b0;
        end else begin
            if (w_wr_compare) r_compare <= cpu_write_data;
            if (w_irq_set)         r_irq <= 1'b1;
            else if (w_wr_compare) r_irq <= 1'b0;
        end
    end
`else
    assign w_irq     = 1'b0;
    assign timer_irq = 1'b0;
`endif

    always_comb begin
        w_status                                     = '0;
        w_status[STATUS_FULL_BIT]                    = w_full;
        w_status[STATUS_EMPTY_BIT]                   = w_empty;
        w_status[STATUS_OVERFLOW_BIT]                = r_overflow;
        w_status[STATUS_IRQ_BIT]                     = w_irq;
        w_status[STATUS_COUNT_MSB:STATUS_COUNT_LSB]  = 5'(w_count);
    end

    always_comb begin
        w_io_rdata = '0;
        case (w_offset)
            REG_SWITCH: w_io_rdata = 16'(r_sw_sync);
            REG_LED:    w_io_rdata = 16'(r_leds);
            REG_TIMER:  w_io_rdata = r_timer;
            REG_STATUS: w_io_rdata = w_status;
`ifdef MEMIO_TIMER_COMPARE_EN
            REG_COMPARE: w_io_rdata = r_compare;
`endif
            default:    w_io_rdata = '0;
        endcase
    end

    // A CPU load of TIMER takes priority over a prescaler tick.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_timer     <= '0;
            r_prescaler <= '0;
        end else if (w_wr_timer) begin
            r_timer     <= cpu_write_data;
            r_prescaler <= '0;
        end else if (w_tick) begin
            r_timer     <= w_timer_inc;
            r_prescaler <= '0;
        end else begin
            r_prescaler <= r_prescaler + PW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sw_meta  <= '0;
            r_sw_sync  <= '0;
            r_leds     <= '0;
            r_overflow <= 1'b0;
            r_is_io    <= 1'b0;
            r_io_data  <= '0;
        end else begin
            r_sw_meta <= switches;
            r_sw_sync <= r_sw_meta;
            r_is_io   <= w_is_io;
            r_io_data <= w_io_rdata;
            if (w_wr_led) r_leds <= cpu_write_data[SWITCH_WIDTH-1:0];
            if (w_push & ~w_accept) r_overflow <= 1'b1;
            else if (w_wr_status)   r_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_memory_io_bridge.sv
// Directed, table-driven bench for memory_io_bridge with a behavioural
// synchronous RAM; compare-timer checks build only with MEMIO_TIMER_COMPARE_EN.
module tb_memory_io_bridge;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] cpuAddress;
    logic        cpuWriteEnable;
    logic [15:0] cpuWriteData;
    logic [15:0] cpuReadData;
    logic [15:0] ramAddress;
    logic        ramWriteEnable;
    logic [15:0] ramWriteData;
    logic [15:0] ramReadData = 16'h0000;
    logic [9:0]  switches;
    logic [9:0]  leds;
    logic        outValid;
    logic [15:0] outData;
    logic        outReady;
    logic        timerIrq;

    logic [15:0] ramMem [65536];

    int nTests  = 0;
    int nFailed = 0;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
        logic        chk;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [14];

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ramWriteEnable) ramMem[ramAddress] <= ramWriteData;
        ramReadData <= ramMem[ramAddress];
    end

    memory_io_bridge #(
        .IO_BASE      (16'hFF00),
        .FIFO_DEPTH   (8),
        .TIMER_DIVIDE (4),
        .SWITCH_WIDTH (10)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .cpu_address      (cpuAddress),
        .cpu_write_enable (cpuWriteEnable),
        .cpu_write_data   (cpuWriteData),
        .cpu_read_data    (cpuReadData),
        .ram_address      (ramAddress),
        .ram_write_enable (ramWriteEnable),
        .ram_write_data   (ramWriteData),
        .ram_read_data    (ramReadData),
        .switches         (switches),
        .leds             (leds),
        .out_valid        (outValid),
        .out_data         (outData),
        .out_ready        (outReady),
        .timer_irq        (timerIrq)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nTests++;
        if (actual !== expected) begin
            nFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drives one bus cycle, samples the combinational RAM strobe mid-cycle,
    // and returns #1 after the rising edge so the registered read is visible.
    task automatic applyStimulus(input logic [15:0] addr, input logic we, input logic [15:0] data,
                                 output logic rweSeen);
        cpuAddress     = addr;
        cpuWriteEnable = we;
        cpuWriteData   = data;
        @(negedge clock);
        rweSeen = ramWriteEnable;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int cycles);
        logic dummy;
        for (int i = 0; i < cycles; i++) applyStimulus(16'h0000, 1'b0, 16'h0000, dummy);
    endtask

    task automatic popAndCheck(input string name, input logic [15:0] expected);
        outReady = 1'b1;
        cpuAddress = 16'h0000;
        cpuWriteEnable = 1'b0;
        @(negedge clock);
        checkOutput({name, "_valid"}, 32'(outValid), 32'd1);
        checkOutput({name, "_data"}, 32'(outData), 32'(expected));
        @(posedge clock);
        #1;
        outReady = 1'b0;
    endtask

    initial begin
        logic        rwe;
        logic [15:0] expFifo [8];

        vecs[0]  = '{16'h0010, 1'b1, 16'h1234, 1'b0, 16'h0000, "ram_write"};
        vecs[1]  = '{16'h0010, 1'b0, 16'h0000, 1'b1, 16'h1234, "ram_read"};
        vecs[2]  = '{16'hFF01, 1'b1, 16'h03FF, 1'b0, 16'h0000, "led_write"};
        vecs[3]  = '{16'hFF01, 1'b0, 16'h0000, 1'b1, 16'h03FF, "led_read"};
        vecs[4]  = '{16'hFF00, 1'b0, 16'h0000, 1'b1, 16'h02A5, "switch_read"};
        vecs[5]  = '{16'h0010, 1'b0, 16'h0000, 1'b1, 16'h1234, "ram_reread"};
        vecs[6]  = '{16'hFEFF, 1'b1, 16'hBEEF, 1'b0, 16'h0000, "ram_top_write"};
        vecs[7]  = '{16'hFEFF, 1'b0, 16'h0000, 1'b1, 16'hBEEF, "ram_top_read"};
        vecs[8]  = '{16'hFF07, 1'b0, 16'h0000, 1'b1, 16'h0000, "reserved_read"};
        vecs[9]  = '{16'hFF07, 1'b1, 16'h5555, 1'b0, 16'h0000, "reserved_write"};
        vecs[10] = '{16'hFF07, 1'b0, 16'h0000, 1'b1, 16'h0000, "reserved_reread"};
        vecs[11] = '{16'hFF03, 1'b0, 16'h0000, 1'b1, 16'h0000, "fifo_data_read"};
`ifdef MEMIO_TIMER_COMPARE_EN
        vecs[12] = '{16'hFF05, 1'b0, 16'h0000, 1'b1, 16'hFFFF, "compare_read"};
`else
        vecs[12] = '{16'hFF05, 1'b0, 16'h0000, 1'b1, 16'h0000, "compare_read"};
`endif
        vecs[13] = '{16'hFF04, 1'b0, 16'h0000, 1'b1, 16'h0002, "status_idle"};

        reset = 1'b0;
        cpuAddress = 16'h0000;
        cpuWriteEnable = 1'b0;
        cpuWriteData = 16'h0000;
        switches = 10'h2A5;
        outReady = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_leds", 32'(leds), 32'd0);
        checkOutput("reset_out_valid", 32'(outValid), 32'd0);
        checkOutput("reset_out_data", 32'(outData), 32'd0);
        checkOutput("reset_timer_irq", 32'(timerIrq), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        idle(3);

        $display("[TB] register and RAM vectors");
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].addr, vecs[i].we, vecs[i].wdata, rwe);
            checkOutput({vecs[i].name, "_ram_we"}, 32'(rwe),
                        32'(vecs[i].we && (vecs[i].addr < 16'hFF00)));
            if (vecs[i].chk) checkOutput(vecs[i].name, 32'(cpuReadData), 32'(vecs[i].exp));
        end
        checkOutput("leds_value", 32'(leds), 32'h3FF);

        $display("[TB] timer sequence");
        applyStimulus(16'hFF02, 1'b1, 16'hFFFE, rwe);
        idle(8);
        applyStimulus(16'hFF02, 1'b0, 16'h0000, rwe);
        checkOutput("timer_wrap", 32'(cpuReadData), 32'h0000);
        idle(2);
        applyStimulus(16'hFF02, 1'b1, 16'h1000, rwe);
        applyStimulus(16'hFF02, 1'b0, 16'h0000, rwe);
        checkOutput("timer_write_on_tick", 32'(cpuReadData), 32'h1000);
        idle(3);
        applyStimulus(16'hFF02, 1'b0, 16'h0000, rwe);
        checkOutput("timer_after_load", 32'(cpuReadData), 32'h1001);

        $display("[TB] FIFO overflow sequence");
        for (int k = 1; k <= 9; k++) applyStimulus(16'hFF03, 1'b1, 16'(k), rwe);
        applyStimulus(16'hFF04, 1'b0, 16'h0000, rwe);
        checkOutput("status_full_ovf", 32'(cpuReadData), 32'h0085);
        for (int k = 1; k <= 8; k++) popAndCheck($sformatf("drain%0d", k), 16'(k));
        checkOutput("drained_valid", 32'(outValid), 32'd0);
        checkOutput("drained_data", 32'(outData), 32'd0);
        applyStimulus(16'hFF04, 1'b0, 16'h0000, rwe);
        checkOutput("status_empty_ovf", 32'(cpuReadData), 32'h0006);
        applyStimulus(16'hFF04, 1'b1, 16'h0000, rwe);
        applyStimulus(16'hFF04, 1'b0, 16'h0000, rwe);
        checkOutput("status_ovf_cleared", 32'(cpuReadData), 32'h0002);

        $display("[TB] FIFO full push with pop");
        for (int k = 0; k < 8; k++) applyStimulus(16'hFF03, 1'b1, 16'h0011 + 16'(k), rwe);
        outReady = 1'b1;
        applyStimulus(16'hFF03, 1'b1, 16'hAAAA, rwe);
        outReady = 1'b0;
        applyStimulus(16'hFF04, 1'b0, 16'h0000, rwe);
        checkOutput("status_full_pushpop", 32'(cpuReadData), 32'h0081);
        expFifo = '{16'h0012, 16'h0013, 16'h0014, 16'h0015, 16'h0016, 16'h0017, 16'h0018, 16'hAAAA};
        for (int k = 0; k < 8; k++) popAndCheck($sformatf("pushpop%0d", k), expFifo[k]);
        checkOutput("pushpop_empty", 32'(outValid), 32'd0);

        $display("[TB] reset mid-operation");
        applyStimulus(16'hFF03, 1'b1, 16'h0077, rwe);
        applyStimulus(16'hFF03, 1'b1, 16'h0088, rwe);
        cpuWriteEnable = 1'b0;
        checkOutput("pre_reset_valid", 32'(outValid), 32'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("async_reset_valid", 32'(outValid), 32'd0);
        checkOutput("async_reset_data", 32'(outData), 32'd0);
        checkOutput("async_reset_leds", 32'(leds), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        applyStimulus(16'hFF04, 1'b0, 16'h0000, rwe);
        checkOutput("post_reset_status", 32'(cpuReadData), 32'h0002);

`ifdef MEMIO_TIMER_COMPARE_EN
        $display("[TB] timer compare");
        applyStimulus(16'hFF02, 1'b1, 16'h0000, rwe);
        applyStimulus(16'hFF05, 1'b1, 16'h0003, rwe);
        idle(8);
        checkOutput("irq_before_match", 32'(timerIrq), 32'd0);
        idle(4);
        checkOutput("irq_on_match", 32'(timerIrq), 32'd1);
        idle(5);
        checkOutput("irq_sticky", 32'(timerIrq), 32'd1);
        applyStimulus(16'hFF05, 1'b1, 16'hFFFF, rwe);
        checkOutput("irq_cleared", 32'(timerIrq), 32'd0);
`else
        idle(10);
        checkOutput("irq_disabled", 32'(timerIrq), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", nTests, nFailed);
        $finish;
    end

endmodule
